// File: rtl/word_scroll_ctrl.sv
// Scrolls one word (or the full text) out of an external character ROM at a
// programmable character period. Optional auto-repeat: define SCROLL_LOOP_EN.
module word_scroll_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] word_sel,
  input  logic [1:0] rate,
  input  logic       repeat_req,
  input  logic [7:0] rom_data,
  output logic [7:0] rom_addr,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, EMIT, PACE, DONE} state_t;

  state_t     state_reg, state_next;
  logic [2:0] sel_reg, sel_next;
  logic [1:0] rate_reg, rate_next;
  logic [7:0] addr_reg, addr_next;
  logic [5:0] remain_reg, remain_next;
  logic [7:0] pace_reg, pace_next;
  logic [7:0] char_reg, char_next;
  logic       valid_reg, valid_next;
  logic [13:0] load_entry;
  logic [7:0]  pace_init;

  // Word table packed as {base[7:0], length[5:0]}; 6 and 7 select the whole text.
  function automatic logic [13:0] word_entry(input logic [2:0] s);
    case (s)
      3'd0:    word_entry = {8'd0,  6'd9};
      3'd1:    word_entry = {8'd10, 6'd6};
      3'd2:    word_entry = {8'd17, 6'd10};
      3'd3:    word_entry = {8'd28, 6'd5};
      3'd4:    word_entry = {8'd34, 6'd11};
      3'd5:    word_entry = {8'd46, 6'd4};
      default: word_entry = {8'd0,  6'd51};
    endcase
  endfunction

  // EMIT plus (P-1) PACE cycles gives exactly P cycles between emissions.
  always_comb begin
    case (rate_reg)
      2'd0:    pace_init = 8'd2;
      2'd1:    pace_init = 8'd14;
      2'd2:    pace_init = 8'd62;
      default: pace_init = 8'd254;
    endcase
  end

`ifdef SCROLL_LOOP_EN
  assign load_entry = (state_reg == IDLE) ? word_entry(word_sel) : word_entry(sel_reg);
`else
  wire unused_repeat_req = repeat_req;
  assign load_entry = word_entry(word_sel);
`endif

  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    rate_next   = rate_reg;
    addr_next   = addr_reg;
    remain_next = remain_reg;
    pace_next   = pace_reg;
    char_next   = char_reg;
    valid_next  = 1'b0;
    if (abort && state_reg != IDLE) begin
      state_next = IDLE;
    end else if (ena) begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            sel_next    = word_sel;
            rate_next   = rate;
            addr_next   = load_entry[13:6];
            remain_next = load_entry[5:0] - 6'd1;
            state_next  = EMIT;
          end
        end
        EMIT: begin
          char_next  = rom_data;
          valid_next = 1'b1;
          pace_next  = pace_init;
          state_next = PACE;
        end
        PACE: begin
          if (pace_reg != 8'd0) begin
            pace_next = pace_reg - 8'd1;
          end else if (remain_reg != 6'd0) begin
            addr_next   = addr_reg + 8'd1;
            remain_next = remain_reg - 6'd1;
            state_next  = EMIT;
          end else begin
`ifdef SCROLL_LOOP_EN
            if (repeat_req) begin
              addr_next   = load_entry[13:6];
              remain_next = load_entry[5:0] - 6'd1;
              state_next  = EMIT;
            end else begin
              state_next = DONE;
            end
`else
            state_next = DONE;
`endif
          end
        end
        DONE: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      sel_reg    <= 3'd0;
      rate_reg   <= 2'd0;
      addr_reg   <= 8'd0;
      remain_reg <= 6'd0;
      pace_reg   <= 8'd0;
      char_reg   <= 8'h20;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sel_reg    <= sel_next;
      rate_reg   <= rate_next;
      addr_reg   <= addr_next;
      remain_reg <= remain_next;
      pace_reg   <= pace_next;
      char_reg   <= char_next;
      valid_reg  <= valid_next;
    end
  end

  assign rom_addr   = addr_reg;
  assign char_out   = char_reg;
  assign char_valid = valid_reg;
  assign busy       = (state_reg != IDLE);
  // An abort arriving during DONE suppresses the completion pulse.
  assign done       = (state_reg == DONE) && ena && !abort;

endmodule

// File: tb/tb_word_scroll_ctrl.sv
// Directed self-checking bench for word_scroll_ctrl with a behavioural 51-char ROM.
module tb_word_scroll_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic       abort;
  logic [2:0] word_sel;
  logic [1:0] rate;
  logic       repeat_req;
  logic [7:0] rom_data;
  logic [7:0] rom_addr;
  logic [7:0] char_out;
  logic       char_valid;
  logic       busy;
  logic       done;

  word_scroll_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .abort(abort),
    .word_sel(word_sel), .rate(rate), .repeat_req(repeat_req), .rom_data(rom_data),
    .rom_addr(rom_addr), .char_out(char_out), .char_valid(char_valid),
    .busy(busy), .done(done)
  );

  logic [7:0] rom_mem [0:255];
  assign rom_data = rom_mem[rom_addr];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] chars[$];
  int         cycs[$];
  logic [7:0] addrs[$];
  int done_cnt, done_cyc, start_cyc, glitch;
  bit timed_out;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Start a playback and record every emitted character until busy drops.
  task automatic play(input logic [2:0] sel, input logic [1:0] r,
                      input int freeze_after, input int abort_after, input int max_cyc);
    chars.delete(); cycs.delete(); addrs.delete();
    done_cnt = 0; done_cyc = -1; glitch = 0; timed_out = 1'b1;
    word_sel = sel; rate = r; start = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    start = 1'b0; word_sel = 3'd0; rate = 2'd3;
    for (int n = 0; n < max_cyc; n++) begin
      @(negedge clk);
      if (char_valid) begin
        chars.push_back(char_out); cycs.push_back(cyc); addrs.push_back(rom_addr);
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (freeze_after > 0 && char_valid && chars.size() == freeze_after) begin
        ena = 1'b0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (char_valid || done) glitch++;
        end
        ena = 1'b1;
      end
      if (abort_after > 0 && char_valid && chars.size() == abort_after) begin
        abort = 1'b1; timed_out = 1'b0;
        break;
      end
      if (!busy) begin timed_out = 1'b0; break; end
    end
    $display("play word=%0d rate=%0d chars=%0d dones=%0d", sel, r, chars.size(), done_cnt);
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rom_addr !== 8'h00) begin failures++; $display("FAIL reset_addr got=%h exp=00", rom_addr); end
    checks++; if (char_out !== 8'h20) begin failures++; $display("FAIL reset_char got=%h exp=20", char_out); end
    checks++; if (char_valid !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", char_valid, done); end
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_fuego;
    logic [7:0] exp [5] = '{8'h46, 8'h75, 8'h65, 8'h67, 8'h6F};
    play(3'd3, 2'd0, 0, 0, 200);
    checks++; if (timed_out) begin failures++; $display("FAIL fuego_timeout got=busy exp=idle"); end
    checks++; if (chars.size() != 5) begin failures++; $display("FAIL fuego_count got=%0d exp=5", chars.size()); end
    for (int i = 0; i < 5 && i < chars.size(); i++) begin
      checks++; if (chars[i] !== exp[i]) begin failures++; $display("FAIL fuego_char%0d got=%h exp=%h", i, chars[i], exp[i]); end
      if (i > 0) begin
        checks++; if (cycs[i] - cycs[i-1] != 4) begin failures++; $display("FAIL fuego_gap%0d got=%0d exp=4", i, cycs[i] - cycs[i-1]); end
      end
    end
    if (chars.size() == 5) begin
      checks++; if (cycs[0] != start_cyc + 1) begin failures++; $display("FAIL fuego_latency got=%0d exp=%0d", cycs[0], start_cyc + 1); end
      checks++; if (done_cyc != cycs[4] + 3) begin failures++; $display("FAIL fuego_done_cyc got=%0d exp=%0d", done_cyc, cycs[4] + 3); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL fuego_done got=%0d exp=1", done_cnt); end
    checks++; if (busy !== 1'b0 || char_out !== 8'h6F) begin failures++; $display("FAIL fuego_end got=%b/%h exp=0/6f", busy, char_out); end
  endtask

  task automatic test_full_text;
    play(3'd6, 2'd1, 0, 0, 1200);
    checks++; if (timed_out) begin failures++; $display("FAIL full_timeout got=busy exp=idle"); end
    checks++; if (chars.size() != 51) begin failures++; $display("FAIL full_count got=%0d exp=51", chars.size()); end
    for (int i = 0; i < chars.size() && i < 51; i++) begin
      checks++; if (chars[i] !== rom_mem[i] || addrs[i] !== 8'(i)) begin
        failures++; $display("FAIL full_char%0d got=%h@%0d exp=%h@%0d", i, chars[i], addrs[i], rom_mem[i], i); end
      if (i > 0) begin
        checks++; if (cycs[i] - cycs[i-1] != 16) begin failures++; $display("FAIL full_gap%0d got=%0d exp=16", i, cycs[i] - cycs[i-1]); end
      end
    end
    if (chars.size() == 51) begin
      checks++; if (chars[50] !== 8'h20) begin failures++; $display("FAIL full_last got=%h exp=20", chars[50]); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL full_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_abort;
    play(3'd4, 2'd0, 0, 3, 200);
    checks++; if (timed_out) begin failures++; $display("FAIL abort_timeout got=no_third exp=third_char"); end
    @(negedge clk);
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (char_out !== 8'h6E) begin failures++; $display("FAIL abort_char got=%h exp=6e", char_out); end
    checks++; if (rom_addr !== 8'd36) begin failures++; $display("FAIL abort_addr got=%0d exp=36", rom_addr); end
    for (int k = 0; k < 12; k++) begin
      if (char_valid || done || busy) glitch++;
      @(negedge clk);
    end
    checks++; if (glitch != 0 || done_cnt != 0) begin failures++; $display("FAIL abort_quiet got=%0d exp=0", glitch + done_cnt); end
  endtask

  task automatic test_freeze;
    logic [7:0] exp [4] = '{8'h41, 8'h67, 8'h75, 8'h61};
    int exp_gap [4] = '{0, 4, 24, 4};
    play(3'd5, 2'd0, 2, 0, 200);
    checks++; if (timed_out || chars.size() != 4) begin failures++; $display("FAIL freeze_count got=%0d exp=4", chars.size()); end
    for (int i = 0; i < 4 && i < chars.size(); i++) begin
      checks++; if (chars[i] !== exp[i]) begin failures++; $display("FAIL freeze_char%0d got=%h exp=%h", i, chars[i], exp[i]); end
      if (i > 0) begin
        checks++; if (cycs[i] - cycs[i-1] != exp_gap[i]) begin failures++; $display("FAIL freeze_gap%0d got=%0d exp=%0d", i, cycs[i] - cycs[i-1], exp_gap[i]); end
      end
    end
    checks++; if (glitch != 0) begin failures++; $display("FAIL freeze_pulses got=%0d exp=0", glitch); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL freeze_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_start_held;
    int pulses = 0;
    bit seen_done = 1'b0;
    logic [7:0] last = 8'h00;
    word_sel = 3'd1; rate = 2'd0; start = 1'b1;
    for (int n = 0; n < 200 && !seen_done; n++) begin
      @(negedge clk);
      if (char_valid) begin pulses++; last = char_out; end
      if (done) seen_done = 1'b1;
    end
    checks++; if (!seen_done || pulses != 6) begin failures++; $display("FAIL held_pulses got=%0d exp=6", pulses); end
    checks++; if (last !== 8'h61) begin failures++; $display("FAIL held_last got=%h exp=61", last); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL held_idle got=%b exp=0", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || rom_addr !== 8'd10) begin failures++; $display("FAIL held_restart got=%b/%0d exp=1/10", busy, rom_addr); end
    $display("held_start word=1 pulses=%0d restarted=%b", pulses, busy);
    start = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL held_abort got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid;
    play(3'd2, 2'd0, 0, 2, 200);
    abort = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || rom_addr !== 8'h00 || char_out !== 8'h20 || char_valid !== 1'b0) begin
      failures++; $display("FAIL async_reset got=%b/%h/%h/%b exp=0/00/20/0", busy, rom_addr, char_out, char_valid); end
    glitch = 0;
    for (int k = 0; k < 4; k++) begin @(negedge clk); if (done || busy) glitch++; end
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin @(negedge clk); if (done || busy || char_valid) glitch++; end
    checks++; if (glitch != 0) begin failures++; $display("FAIL reset_abandon got=%0d exp=0", glitch); end
  endtask

`ifdef SCROLL_LOOP_EN
  task automatic test_repeat;
    logic [7:0] exp [4] = '{8'h41, 8'h67, 8'h75, 8'h61};
    int n_chars = 0; int prev = 0; int bad = 0;
    repeat_req = 1'b1; word_sel = 3'd5; rate = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 200 && n_chars < 8; n++) begin
      @(negedge clk);
      if (done || !busy) bad++;
      if (char_valid) begin
        if (char_out !== exp[n_chars % 4] || (n_chars > 0 && cyc - prev != 4)) bad++;
        n_chars++; prev = cyc;
      end
    end
    checks++; if (n_chars != 8 || bad != 0) begin failures++; $display("FAIL loop_seq got=%0d/%0d exp=8/0", n_chars, bad); end
    repeat_req = 1'b0;
    done_cnt = 0;
    for (int n = 0; n < 100 && busy; n++) begin @(negedge clk); if (done) done_cnt++; end
    checks++; if (done_cnt != 1 || busy !== 1'b0) begin failures++; $display("FAIL loop_stop got=%0d exp=1", done_cnt); end
    $display("loop word=5 chars=%0d dones=%0d", n_chars, done_cnt);
  endtask
`else
  task automatic test_repeat;
    repeat_req = 1'b1;
    play(3'd5, 2'd0, 0, 0, 200);
    repeat_req = 1'b0;
    checks++; if (timed_out || chars.size() != 4 || done_cnt != 1) begin
      failures++; $display("FAIL repeat_ignored got=%0d/%0d exp=4/1", chars.size(), done_cnt); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0;
    word_sel = 3'd0; rate = 2'd0; repeat_req = 1'b0;
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'h3F;
    begin
      string text = "Elementos Tierra Naturaleza Fuego Conmutacion Agua ";
      for (int i = 0; i < text.len(); i++) rom_mem[i] = text[i];
    end
    test_reset();
    test_fuego();
    test_full_text();
    test_abort();
    test_freeze();
    test_start_held();
    test_repeat();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
